i2s_rx: RTL

I2S serial-audio receiver: the capture-side counterpart of the codec DAC transmit path. It oversamples the codec's BCLK, LRCLK and ADC SDATA in the fabric clock domain and deserialises one left/right sample pair per LRCLK frame. It presents each pair on a ready/valid interface for downstream DSP or loopback to the DAC path. The codec is the clock master; this block only observes BCLK and LRCLK.

---
 rtl/i2s_rx.sv | 103 ++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver that deserialises one left/right pair per LRCLK frame onto a ready/valid port.
module i2s_rx #(
  parameter int width_p = 24,
  parameter int sync_stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               bclk_i,
  input  logic               lrclk_i,
  input  logic               sdata_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_l_o,
  output logic [width_p-1:0] data_r_o,
  output logic               overrun_o,
  output logic               frame_err_o
);
  localparam int cw = $clog2(width_p);
  localparam logic [cw-1:0] cnt_max = cw'(width_p - 1);
  typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, IGNORE} state_t;
  state_t state;
  logic [sync_stages_p-1:0] bclk_q, lr_q, sd_q;
  logic bclk_d, bclk_s, lr_s, sd_s, rise;
  logic lr_prev, primed, chan, left_ok;
  logic lr_edge, done, load;
  logic [cw-1:0] cnt;
  logic [width_p-1:0] shreg, hold_l, word;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bclk_q <= '0;
      lr_q <= '0;
      sd_q <= '0;
      bclk_d <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[sync_stages_p-2:0], bclk_i};
      lr_q <= {lr_q[sync_stages_p-2:0], lrclk_i};
      sd_q <= {sd_q[sync_stages_p-2:0], sdata_i};
      bclk_d <= bclk_s;
    end
  end
  // primed suppresses a false LR edge against the reset value of lr_prev
  always_comb begin
    bclk_s = bclk_q[sync_stages_p-1];
    lr_s = lr_q[sync_stages_p-1];
    sd_s = sd_q[sync_stages_p-1];
    rise = bclk_s && !bclk_d;
    lr_edge = primed && (lr_s != lr_prev);
    word = {shreg[width_p-2:0], sd_s};
    done = rise && state == SHIFT && !lr_edge && cnt == cnt_max;
    load = done && chan && left_ok;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ALIGN;
      lr_prev <= 1'b0;
      primed <= 1'b0;
      chan <= 1'b0;
      left_ok <= 1'b0;
      cnt <= '0;
      shreg <= '0;
      hold_l <= '0;
      valid_o <= 1'b0;
      data_l_o <= '0;
      data_r_o <= '0;
      overrun_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      overrun_o <= load && valid_o && !ready_i;
      frame_err_o <= rise && state == SHIFT && lr_edge;
      valid_o <= load || (valid_o && !ready_i);
      if (load) begin
        data_l_o <= hold_l;
        data_r_o <= word;
      end
      if (rise) begin
        lr_prev <= lr_s;
        primed <= 1'b1;
        case (state)
          ALIGN, IGNORE: if (lr_edge) begin
            state <= DELAY;
            chan <= lr_s;
            cnt <= '0;
          end
          DELAY: state <= SHIFT;
          SHIFT: if (lr_edge) begin
            state <= DELAY;
            chan <= lr_s;
            cnt <= '0;
            left_ok <= 1'b0;
          end else begin
            shreg <= word;
            cnt <= cnt + 1'b1;
            if (done) begin
              state <= IGNORE;
              left_ok <= !chan;
              if (!chan) hold_l <= word;
            end
          end
        endcase
      end
    end
  end
endmodule
